// File: rtl/mouse_tracker_param.sv
// Cursor tracker that sits between the ps2_mouse decoder and the game logic.
// Integrates PS/2 motion packets into a clamped screen position, maps the
// position onto a block grid, generates click pulses, and detects an
// N-consecutive-right-click cheat gesture that expires after a timeout.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   pkt_*               : decoded packet fields, valid while pkt_valid=1
//   freeze              : hold cursor, count and timeout; suppress pulses
//   recenter            : move the cursor to screen centre
//   mouse_x/mouse_y     : cursor position
//   mouse_inblock/_x/_y : grid hit flag and block coordinates
//   l_click/r_click     : one-cycle press pulses
//   l_held              : stored left-button level
//   cheat_activate      : one-cycle pulse when the gesture completes
module mouse_tracker_param #(
  parameter int unsigned SCREEN_W      = 640,
  parameter int unsigned SCREEN_H      = 480,
  parameter int unsigned SPEED_SHIFT   = 0,
  parameter int unsigned GRID_X0       = 64,
  parameter int unsigned GRID_Y0       = 0,
  parameter int unsigned BLOCK_W       = 32,
  parameter int unsigned BLOCK_H       = 60,
  parameter int unsigned GRID_COLS     = 18,
  parameter int unsigned GRID_ROWS     = 8,
  parameter int unsigned CHEAT_CLICKS  = 4,
  parameter int unsigned CHEAT_TIMEOUT = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [7:0] pkt_x,
  input  logic       pkt_x_sign,
  input  logic       pkt_x_ov,
  input  logic [7:0] pkt_y,
  input  logic       pkt_y_sign,
  input  logic       pkt_y_ov,
  input  logic       pkt_l,
  input  logic       pkt_r,
  input  logic       freeze,
  input  logic       recenter,
  output logic [9:0] mouse_x,
  output logic [8:0] mouse_y,
  output logic       mouse_inblock,
  output logic [4:0] mouse_block_x,
  output logic [2:0] mouse_block_y,
  output logic       l_click,
  output logic       r_click,
  output logic       l_held,
  output logic       cheat_activate
);

  localparam int unsigned TMO_W = (CHEAT_TIMEOUT < 2) ? 1 : $clog2(CHEAT_TIMEOUT + 1);
  localparam int unsigned CNT_W = 3;
  localparam logic [9:0]  CX = 10'(SCREEN_W / 2);
  localparam logic [8:0]  CY = 9'(SCREEN_H / 2);
  localparam logic signed [12:0] X_MAX = 13'(SCREEN_W - 1);
  localparam logic signed [12:0] Y_MAX = 13'(SCREEN_H - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(CHEAT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_FIRE  = CNT_W'(CHEAT_CLICKS);

  // Map a pixel to {inblock, block_x, block_y}; quotient found by a compare chain.
  function automatic logic [8:0] map_blk(input logic [9:0] x, input logic [8:0] y);
    logic       inb;
    logic [4:0] bx;
    logic [2:0] by;
    int         xo;
    int         yo;
    xo  = int'(x) - int'(GRID_X0);
    yo  = int'(y) - int'(GRID_Y0);
    bx  = '0;
    by  = '0;
    inb = (xo >= 0) && (xo < int'(GRID_COLS * BLOCK_W)) &&
          (yo >= 0) && (yo < int'(GRID_ROWS * BLOCK_H));
    if (inb) begin
      for (int k = 1; k < int'(GRID_COLS); k++)
        if (xo >= k * int'(BLOCK_W)) bx = 5'(k);
      for (int k = 1; k < int'(GRID_ROWS); k++)
        if (yo >= k * int'(BLOCK_H)) by = 3'(k);
    end
    return {inb, bx, by};
  endfunction

  logic                 r_lvl;
  logic [CNT_W-1:0]     cnt_q;
  logic [TMO_W-1:0]     tmo_q;

  logic signed [12:0]   dx_c, dy_c, nx_c, ny_c;
  logic [9:0]           x_mv_c;
  logic [8:0]           y_mv_c;
  logic                 l_press_c, r_press_c, tmo_hit_c, cheat_c;
  logic [CNT_W-1:0]     cnt_c, base_c, inc_c;
  logic [TMO_W-1:0]     tmo_c;

  // Scaled motion deltas; an overflowed axis contributes nothing. Screen y grows downward.
  always_comb begin
    dx_c = '0;
    dy_c = '0;
    if (!pkt_x_ov) dx_c = $signed({{4{pkt_x_sign}}, pkt_x_sign, pkt_x}) <<< SPEED_SHIFT;
    if (!pkt_y_ov) dy_c = -($signed({{4{pkt_y_sign}}, pkt_y_sign, pkt_y}) <<< SPEED_SHIFT);
    nx_c = $signed({3'b000, mouse_x}) + dx_c;
    ny_c = $signed({4'b0000, mouse_y}) + dy_c;
    if (nx_c < 13'sd0)      x_mv_c = '0;
    else if (nx_c > X_MAX)  x_mv_c = 10'(X_MAX);
    else                    x_mv_c = nx_c[9:0];
    if (ny_c < 13'sd0)      y_mv_c = '0;
    else if (ny_c > Y_MAX)  y_mv_c = 9'(Y_MAX);
    else                    y_mv_c = ny_c[8:0];
  end

  // Press detection and cheat counter next state; a left press beats a right press.
  always_comb begin
    l_press_c = pkt_valid & pkt_l & ~l_held;
    r_press_c = pkt_valid & pkt_r & ~r_lvl;
    tmo_hit_c = (cnt_q != '0) && (tmo_q == TMO_LIMIT);
    cnt_c     = cnt_q;
    tmo_c     = tmo_q;
    cheat_c   = 1'b0;
    base_c    = tmo_hit_c ? '0 : cnt_q;
    inc_c     = base_c + CNT_W'(1);
    if (!freeze) begin
      if (l_press_c) begin
        cnt_c = '0;
        tmo_c = '0;
      end else if (r_press_c) begin
        tmo_c = '0;
        if (inc_c == CNT_FIRE) begin
          cnt_c   = '0;
          cheat_c = 1'b1;
        end else begin
          cnt_c = inc_c;
        end
      end else if (tmo_hit_c) begin
        cnt_c = '0;
        tmo_c = '0;
      end else if (cnt_q != '0) begin
        tmo_c = tmo_q + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mouse_x        <= CX;
      mouse_y        <= CY;
      {mouse_inblock, mouse_block_x, mouse_block_y} <= map_blk(CX, CY);
      l_click        <= 1'b0;
      r_click        <= 1'b0;
      l_held         <= 1'b0;
      r_lvl          <= 1'b0;
      cheat_activate <= 1'b0;
      cnt_q          <= '0;
      tmo_q          <= '0;
    end else begin
      if (!freeze) begin
        if (recenter) begin
          mouse_x <= CX;
          mouse_y <= CY;
        end else if (pkt_valid) begin
          mouse_x <= x_mv_c;
          mouse_y <= y_mv_c;
        end
      end
      {mouse_inblock, mouse_block_x, mouse_block_y} <= map_blk(mouse_x, mouse_y);
      // Levels track every packet, even frozen ones, so unfreezing makes no false edge.
      if (pkt_valid) begin
        l_held <= pkt_l;
        r_lvl  <= pkt_r;
      end
      l_click        <= l_press_c & ~freeze;
      r_click        <= r_press_c & ~freeze;
      cheat_activate <= cheat_c;
      cnt_q          <= cnt_c;
      tmo_q          <= tmo_c;
    end
  end

endmodule
